compare_sched: RTL
==================

# compare_sched

Shared magnitude-compare scheduler. Two requesters share one bit-serial compare engine that evaluates operands MSB-first, one bit per cycle, using the same cascade cell equations as the team's ripple comparator. Arbitration between requesters is round-robin. Results return with a requester ID. The block sits between requesting control logic and the compare resource, replacing per-requester parallel comparators where area matters more than latency.

## Interface
Parameters:
- WIDTH, 4, operand width in bits (≥1)
- EARLY_EXIT, 1, when 1 stop as soon as the result is decided; when 0 always run WIDTH bit cycles

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- req  input  2  request per requester; held high with operands stable until granted
- a0, b0  input  WIDTH  operands, requester 0
- a1, b1  input  WIDTH  operands, requester 1
- gnt  output  2  one-hot, combinational; operands of requester i sampled on the edge where gnt[i]=1
- busy  output  1  engine not idle
- done  output  1  one-cycle result-valid pulse
- done_id  output  1  requester that owns the result
- gt, lt, eq  output  1 each  result, exactly one high after the first done; held until the next done

## Operation
- States: IDLE, RUN, DONE. busy = (state != IDLE).
- IDLE: if req is nonzero, assert gnt for the winner in the same cycle. On the clock edge:
  - capture the winner's a/b into the operand registers
  - clear g_st and l_st
  - set bit index = WIDTH-1
  - record owner
  - go to RUN
- gnt is always 0 outside IDLE, and 0 in IDLE when req is 0.
- Arbitration uses a round-robin pointer `last`:
  - single request: that requester wins
  - both requesting: the requester != last wins
  - on each grant, last := winner
- RUN: each cycle, with a = opA[idx] and b = opB[idx]:
  - g_nx = g_st | (~l_st & a & ~b)
  - l_nx = l_st | (~g_st & ~a & b)
  - register g_nx and l_nx.
- RUN exit to DONE occurs when idx==0, or when EARLY_EXIT=1 and (g_nx|l_nx). Otherwise idx decrements.
- RUN→DONE edge loads the outputs: gt := g_nx, lt := l_nx, eq := ~g_nx & ~l_nx, done_id := owner.
- DONE: done=1 for exactly this cycle, then return to IDLE. No grant is issued in the DONE cycle.
- req changes during RUN/DONE are ignored. Requests wait; nothing is queued inside the block.
- Comparison is unsigned.

## Timing
- Reset (async assert, any state):
  - state := IDLE, last := 1 (requester 0 wins the first contention)
  - gnt=0, busy=0, done=0, done_id=0, gt=lt=eq=0
  - any in-flight operation is dropped with no done pulse.
- Reset deassertion is synchronized externally; the first grant is possible in the first cycle with rst_n high.
- Grant in cycle c0. RUN occupies c1…ck. done is high in ck+1. The earliest next grant is ck+2.
- Worst case (equal operands, or EARLY_EXIT=0): done in c0+WIDTH+1. Back-to-back throughput is one result per WIDTH+2 cycles.
- Early exit when MSBs differ: done in c0+2.
- With WIDTH=1, RUN is always exactly one cycle.
- Results on gt/lt/eq/done_id change only on the RUN→DONE edge, or on reset.

## Test plan
- Reset: hold rst_n=0 with req=2'b11 → gnt=0, busy=0, done=0, gt=lt=eq=0. Assert rst_n mid-RUN → busy drops immediately and no done follows.
- Single request, WIDTH=4, EARLY_EXIT=1, req=01, a0=4'b1000, b0=4'b0111 → gnt=01 in c0, done in c2, gt=1, done_id=0.
- Equal operands: req=10, a1=b1=4'd9 → done in c0+5, eq=1, gt=lt=0, done_id=1. a1=3, b1=12 → lt=1.
- Decided at LSB: a0=4'd6, b0=4'd7 → done in c0+5, lt=1. Repeat with EARLY_EXIT=0 and a0=8, b0=0 → done still in c0+5, gt=1.
- Round robin: req held at 11 with a0=5,b0=5 and a1=2,b1=1 → grant order 0,1,0,1. done_id alternates 0,1,0,1. Grants are spaced ≥ WIDTH+2 cycles when operands are equal.
- Exhaustive: all 256 (a,b) pairs through each requester, checking exactly one of gt/lt/eq and agreement with the unsigned relation. Also check that no gnt is ever asserted while busy=1.

Source files
------------

// File: rtl/compare_sched.sv
// Shared bit-serial magnitude comparator: two requesters, round-robin grant,
// MSB-first cascade evaluation with optional early exit once the result is decided.
module compare_sched #(
    parameter int WIDTH      = 4,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic             gt,
    output logic             lt,
    output logic             eq
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic             last;
    logic             owner;
    logic             g_st;
    logic             l_st;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [IW-1:0]    idx;
    logic             win;
    logic             bit_a;
    logic             bit_b;
    logic             g_nx;
    logic             l_nx;
    logic             fin;

    // Contention goes to whoever was not granted last; a lone request always wins.
    always_comb begin
        win   = (req == 2'b11) ? ~last : req[1];
        gnt   = 2'b00;
        if (rst_n && state == IDLE && req != 2'b00)
            gnt = win ? 2'b10 : 2'b01;
        bit_a = opa[idx];
        bit_b = opb[idx];
        g_nx  = g_st | (~l_st & bit_a & ~bit_b);
        l_nx  = l_st | (~g_st & ~bit_a & bit_b);
        fin   = (idx == '0) || (EARLY_EXIT && (g_nx | l_nx));
        busy  = (state != IDLE);
        done  = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            last    <= 1'b1;
            owner   <= 1'b0;
            g_st    <= 1'b0;
            l_st    <= 1'b0;
            opa     <= '0;
            opb     <= '0;
            idx     <= '0;
            done_id <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
            eq      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        opa   <= win ? a1 : a0;
                        opb   <= win ? b1 : b0;
                        g_st  <= 1'b0;
                        l_st  <= 1'b0;
                        idx   <= IW'(WIDTH - 1);
                        owner <= win;
                        last  <= win;
                        state <= RUN;
                    end
                end
                RUN: begin
                    g_st <= g_nx;
                    l_st <= l_nx;
                    if (fin) begin
                        gt      <= g_nx;
                        lt      <= l_nx;
                        eq      <= ~g_nx & ~l_nx;
                        done_id <= owner;
                        state   <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
